// File: rtl/pwm_pkg.sv
// Shared defaults and the duty type for the multi-channel PWM block.
package pwm_pkg;
    localparam int CNT_W_DEF    = 21;
    localparam int PERIOD_DEF   = 2000000;
    localparam int DUTY_RST_DEF = 150000;
    localparam int DUTY_MIN_DEF = 100000;
    localparam int DUTY_MAX_DEF = 200000;

    typedef logic [CNT_W_DEF-1:0] duty_t;
endpackage

// File: rtl/pwm_counter.sv
// Free-running period counter shared by every PWM channel; wrap marks count==PERIOD-1.
module pwm_counter #(
    parameter int CNT_W  = pwm_pkg::CNT_W_DEF,
    parameter int PERIOD = pwm_pkg::PERIOD_DEF
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             en,
    output logic [CNT_W-1:0] count,
    output logic             wrap
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    assign wrap = en && (count == LAST);

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            count <= '0;
        end else if (en) begin
            count <= wrap ? '0 : count + CNT_W'(1);
        end
    end
endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM with shadowed duty registers updated at the period wrap.
// Optional duty saturation to [DUTY_MIN, DUTY_MAX] when PWM_MULTI_CLAMP_EN is defined.
module pwm_multi
    import pwm_pkg::*;
#(
    parameter int NUM_CH   = 4,
    parameter int CNT_W    = CNT_W_DEF,
    parameter int PERIOD   = PERIOD_DEF,
    parameter int DUTY_RST = DUTY_RST_DEF,
    parameter int DUTY_MIN = DUTY_MIN_DEF,
    parameter int DUTY_MAX = DUTY_MAX_DEF,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_in,
    input  logic              rst_n_in,
    input  logic              duty_valid_in,
    input  logic [CH_W-1:0]   duty_ch_in,
    input  logic [CNT_W-1:0]  duty_in,
    output logic              duty_ready_out,
    output logic [NUM_CH-1:0] sig_out,
    output logic              period_start_out,
    output logic              err_out
);
`ifdef PWM_MULTI_CLAMP_EN
    localparam logic [CNT_W-1:0] DMIN = CNT_W'(DUTY_MIN);
    localparam logic [CNT_W-1:0] DMAX = CNT_W'(DUTY_MAX);
`else
    logic unused_clamp_bounds;
    assign unused_clamp_bounds = ^{32'(DUTY_MIN), 32'(DUTY_MAX)};
`endif

    function automatic logic [CNT_W-1:0] clamp_duty(input logic [CNT_W-1:0] d);
`ifdef PWM_MULTI_CLAMP_EN
        if (d < DMIN) return DMIN;
        if (d > DMAX) return DMAX;
        return d;
`else
        return d;
`endif
    endfunction

    logic              running;
    logic [CNT_W-1:0]  count;
    logic              wrap;
    logic [CNT_W-1:0]  active  [NUM_CH];
    logic [CNT_W-1:0]  pending [NUM_CH];
    logic [NUM_CH-1:0] pend_vld;
    logic [NUM_CH-1:0] wr_sel;
    logic [NUM_CH-1:0] sig_p1;
    logic              err;
    logic              wr_acc;
    logic              ch_ok;
    logic [CNT_W-1:0]  duty_sat;

    // The counter holds at 0 for the release cycle so the first period starts cleanly.
    pwm_counter #(.CNT_W(CNT_W), .PERIOD(PERIOD)) u_counter (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .en       (running),
        .count    (count),
        .wrap     (wrap)
    );

    assign wr_acc   = duty_valid_in && running;
    assign ch_ok    = (32'(duty_ch_in) < NUM_CH);
    assign duty_sat = clamp_duty(duty_in);

    always_comb begin
        wr_sel = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            wr_sel[i] = wr_acc && ch_ok && (duty_ch_in == CH_W'(i));
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            running <= 1'b0;
            err     <= 1'b0;
        end else begin
            running <= 1'b1;
            if (wr_acc && !ch_ok) err <= 1'b1;
        end
    end

    // A write landing in the wrap cycle bypasses the shadow and goes straight to active.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int i = 0; i < NUM_CH; i++) active[i] <= CNT_W'(DUTY_RST);
            pend_vld <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (wrap) begin
                    if (wr_sel[i])        active[i] <= duty_sat;
                    else if (pend_vld[i]) active[i] <= pending[i];
                    pend_vld[i] <= 1'b0;
                end else if (wr_sel[i]) begin
                    pend_vld[i] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_in) begin
        for (int i = 0; i < NUM_CH; i++) begin
            if (wr_sel[i]) pending[i] <= duty_sat;
        end
    end

    // Output stage: one cycle behind count.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            sig_p1 <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) sig_p1[i] <= running && (count < active[i]);
        end
    end

    assign sig_out          = sig_p1;
    assign duty_ready_out   = running;
    assign period_start_out = running && (count == '0);
    assign err_out          = err;
endmodule
